// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and default vectors for the fetch sequencer
package fetch_ctrl_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fstate_t;
  localparam word_t RESET_PC_DEF = 32'hbfc00000;
  localparam word_t EXC_PC_DEF   = 32'hbfc00380;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory request/address-ok/data-ok port
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;
  logic  inst_req;
  word_t inst_addr;
  logic  inst_addr_ok;
  logic  inst_data_ok;
  word_t inst_rdata;
  modport master(output inst_req, inst_addr, input inst_addr_ok, inst_data_ok, inst_rdata);
  modport slave(input inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/fetch_ctrl_npc_sel.sv
// fetch_ctrl_npc_sel: next-PC priority mux (exception, eret, branch, sequential)
module fetch_ctrl_npc_sel import fetch_ctrl_pkg::*; #(
  parameter word_t EXC_PC = EXC_PC_DEF
) (
  input  word_t pc,
  input  logic  exc,
  input  logic  eret,
  input  word_t epc,
  input  logic  br_taken,
  input  word_t br_target,
  output word_t npc,
  output logic  redirect
);
  always_comb begin
    redirect = exc | eret | br_taken;
    npc = exc ? EXC_PC : eret ? epc : br_taken ? br_target : pc + 32'd4;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer driving the PC register and the instruction-memory port
module fetch_ctrl import fetch_ctrl_pkg::*; #(
  parameter word_t RESET_PC = RESET_PC_DEF,
  parameter word_t EXC_PC   = EXC_PC_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  word_t pc,
  output logic  pc_en,
  output word_t pc_next,
  input  logic  exc,
  input  logic  eret,
  input  word_t epc,
  input  logic  br_taken,
  input  word_t br_target,
  fetch_ctrl_if.master mem,
  output logic  if_valid,
  output word_t if_inst,
  output word_t if_pc,
  input  logic  stall
);
  fstate_t state, state_nx;
  logic discard, redirect, take, load_addr;
  word_t npc;
  fetch_ctrl_npc_sel #(.EXC_PC(EXC_PC)) u_npc_sel (
    .pc(pc), .exc(exc), .eret(eret), .epc(epc),
    .br_taken(br_taken), .br_target(br_target), .npc(npc), .redirect(redirect)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = REQ;
      REQ:     state_nx = mem.inst_addr_ok ? WAIT : REQ;
      WAIT:    state_nx = !mem.inst_data_ok ? WAIT : take ? HOLD : REQ;
      HOLD:    state_nx = (redirect || !stall) ? REQ : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  // a redirect always wins over accepting the response it races with
  always_comb begin
    take = state == WAIT && mem.inst_data_ok && !discard && !redirect;
    pc_en = !reset && (redirect || take);
    pc_next = pc_en ? npc : '0;
    load_addr = state != REQ && state_nx == REQ;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem.inst_req <= 1'b0;
      mem.inst_addr <= '0;
      discard <= 1'b0;
      if_valid <= 1'b0;
      if_inst <= '0;
      if_pc <= '0;
    end else begin
      mem.inst_req <= state_nx == REQ;
      if (load_addr) mem.inst_addr <= redirect ? npc : pc;
      if (redirect && (state == REQ || (state == WAIT && !mem.inst_data_ok))) discard <= 1'b1;
      else if (state == WAIT && mem.inst_data_ok) discard <= 1'b0;
      if_valid <= state_nx == HOLD;
      if (take) begin
        if_inst <= mem.inst_rdata;
        if_pc <= mem.inst_addr;
      end
    end
  // IDLE only follows reset, so the external PC register must hold its reset value here
  always_ff @(posedge clk)
    if (!reset && state == IDLE) assert (pc == RESET_PC);
endmodule
